io_stage: RTL and testbench
===========================

# io_stage

Memory-response (IO) stage of the five-stage MIPS core. It accepts `ex_to_io_bus_t` entries from EX over a valid/allow-in handshake and, for memory ops, waits for the data-SRAM `data_ok`. It aligns and extends load data (LB/LBU/LH/LHU/LW/LWL/LWR with byte strobes) and forwards the result to WB. It also drives the IO-to-ID bypass bus and discards in-flight responses of flushed instructions.

## Interface
Parameters: none (widths come from `cpu_core_params`).

Ports:
- `clock`  in  1  core clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `ex_to_io_valid`  in  1  EX holds a valid entry
- `ex_to_io_bus`  in  `ex_to_io_bus_t`  EX payload
- `io_allow_in`  out  1  IO accepts an entry this cycle
- `data_ram_data_ok`  in  1  data-SRAM response strobe (one per issued request)
- `data_ram_rdata`  in  32  read data, valid with `data_ok`
- `exception_flush`  in  1  WB exception/ERET flush
- `wb_allow_in`  in  1  WB accepts
- `io_to_wb_valid`  out  1  entry offered to WB
- `io_to_wb_bus`  out  `io_to_wb_bus_t`  pc, write_register, write_strobe[3:0], write_data, HI/LO and CP0/TLB/exception fields passed through
- `io_to_id_back_pass_bus`  out  `io_to_id_back_pass_bus_t`  valid, data_valid, write_register, write_data

## Operation
- Memory op (`has_mem`) = `(result_is_from_memory | memory_write) & !exception_valid`. EX issues the request. IO only collects `data_ok`.
- States:
  - EMPTY: no entry.
  - WAIT_DATA: entry latched, response outstanding.
  - READY: result final.
  - DISCARD: flushed entry, response still owed.
- Transitions:
  - EMPTY or READY accept: `ex_to_io_valid & io_allow_in` latches the bus. The next state is WAIT_DATA if `has_mem`, else READY.
  - READY with `wb_allow_in` and no new entry goes to EMPTY.
  - WAIT_DATA with `data_ok` captures aligned data into the load buffer and goes to READY.
  - DISCARD with `data_ok` goes to EMPTY; the data is dropped.
- Flush has priority over all other transitions:
  - READY goes to EMPTY.
  - WAIT_DATA goes to DISCARD, or to EMPTY if `data_ok` arrives the same cycle.
  - An entry handed over in the flush cycle with `has_mem` goes to DISCARD; otherwise it is not latched.
- `io_allow_in = (state==EMPTY) | (state==READY & wb_allow_in)`. It is 0 in WAIT_DATA and DISCARD.
- `io_to_wb_valid = (state==READY) & !exception_flush`.
- Load alignment (little-endian), with `a = memory_address[1:0]`:
  - LW: `rdata`, strobe 1111.
  - LB/LBU: byte `a`, sign- or zero-extended per `memory_io_unsigned`, strobe 1111.
  - LH/LHU: half `a[1]`, extended the same way, strobe 1111.
  - LWL: `rdata << 8*(3-a)`; strobe is 1000, 1100, 1110, 1111 for a=0..3.
  - LWR: `rdata >> 8*a`; strobe is 1111, 0111, 0011, 0001 for a=0..3.
- Non-load entries:
  - `write_data = alu_result`, strobe 1111.
  - A store completes on `data_ok` with no register write.
  - An entry with `register_write=0` drives `write_strobe=0000`.
- Back-pass bus:
  - `valid` = state ∈ {WAIT_DATA, READY}.
  - `data_valid` = (state==READY).
  - `write_register` = `register_write ? write_register : 0`.
  - `write_data` = the final value.

## Timing
- Reset (async, `reset_n`=0):
  - state EMPTY, all registers 0.
  - `io_to_wb_valid`=0, `io_to_wb_bus`=0, back-pass bus all 0.
  - `io_allow_in`=1.
- Non-memory entry: latched at edge N, `io_to_wb_valid`=1 in cycle N+1.
- Load/store: `data_ok` sampled in cycle M (earliest M = N+1), `io_to_wb_valid` in M+1. There is no combinational `rdata`→output path.
- `data_ok` seen in EMPTY or READY is a protocol error; it is ignored.
- WB stall: READY holds the entry and all outputs stable until `wb_allow_in`.
- Back-to-back: in READY with `wb_allow_in` and `ex_to_io_valid`, the new entry is latched in the same cycle the old one leaves. Zero-bubble throughput for non-memory ops.
- `reset_n` asserted mid-WAIT_DATA returns to EMPTY immediately. The memory side is reset by the same signal.

## Structure
- Package `io_stage_params` (imports `cpu_core_params`, exports `cpu_data_t`/`program_count_t`) holds:
  - `io_to_wb_bus_t`
  - `io_to_id_back_pass_bus_t`
  - `io_state_t` enum {EMPTY, WAIT_DATA, READY, DISCARD}
- Sub-module `load_data_aligner` (combinational): inputs rdata, a, load-type flags, unsigned; outputs write_data and write_strobe.
- `io_stage` holds the FSM, the entry register and the load buffer.

## Test plan
- ALU op, `alu_result`=0x1234_5678, wb_allow_in=1 → `io_to_wb_valid` the next cycle, data 0x1234_5678, strobe 1111; back-pass data_valid=1.
- LB, a=3, rdata=0x80AA_BBCC, data_ok 2 cycles after latch → write_data 0xFFFF_FF80; LBU gives 0x0000_0080; valid 1 cycle after data_ok.
- LWL a=1, rdata=0x4433_2211 → data 0x2211_0000, strobe 1100; LWR a=1 → data 0x0044_3322, strobe 0111.
- Load in WAIT_DATA, then `exception_flush` → DISCARD with `io_allow_in`=0; data_ok later → EMPTY, no WB valid, `io_allow_in`=1.
- Streaming ALU ops with wb_allow_in toggling 1/0 → no entry lost or duplicated, outputs held during stall.
- `reset_n` pulled low during WAIT_DATA → outputs 0 asynchronously; after release, `io_allow_in`=1 and a new op flows normally.

Source files
------------

// File: rtl/cpu_core_params.sv
// rtl/cpu_core_params.sv - core-wide widths and the EX-to-IO pipeline payload
package cpu_core_params;

    localparam int DATA_WIDTH     = 32;
    localparam int PC_WIDTH       = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [DATA_WIDTH-1:0]     cpu_data_t;
    typedef logic [PC_WIDTH-1:0]       program_count_t;
    typedef logic [REG_ADDR_WIDTH-1:0] register_address_t;

    // Load-type flags are one-hot; none set means a full word access.
    typedef struct packed {
        program_count_t    pc;
        cpu_data_t         alu_result;
        cpu_data_t         memory_address;
        logic              result_is_from_memory;
        logic              memory_write;
        logic              memory_io_byte;
        logic              memory_io_half;
        logic              memory_io_left;
        logic              memory_io_right;
        logic              memory_io_unsigned;
        logic              register_write;
        register_address_t write_register;
        logic              hi_write;
        logic              lo_write;
        cpu_data_t         hi_data;
        cpu_data_t         lo_data;
        logic              cp0_write;
        logic [7:0]        cp0_address;
        logic              tlb_probe;
        logic              tlb_read;
        logic              tlb_write_index;
        logic              exception_valid;
        logic [4:0]        exception_code;
        logic              eret;
        logic              in_delay_slot;
        cpu_data_t         bad_virtual_address;
    } ex_to_io_bus_t;

endpackage

// File: rtl/io_stage_pkg.sv
// rtl/io_stage_pkg.sv - IO stage bus types and FSM state encoding
package io_stage_params;

    // Re-exported so IO-stage files only need this one import.
    typedef cpu_core_params::cpu_data_t         cpu_data_t;
    typedef cpu_core_params::program_count_t    program_count_t;
    typedef cpu_core_params::register_address_t register_address_t;
    typedef cpu_core_params::ex_to_io_bus_t     ex_to_io_bus_t;

    typedef struct packed {
        program_count_t    pc;
        register_address_t write_register;
        logic [3:0]        write_strobe;
        cpu_data_t         write_data;
        logic              hi_write;
        logic              lo_write;
        cpu_data_t         hi_data;
        cpu_data_t         lo_data;
        logic              cp0_write;
        logic [7:0]        cp0_address;
        logic              tlb_probe;
        logic              tlb_read;
        logic              tlb_write_index;
        logic              exception_valid;
        logic [4:0]        exception_code;
        logic              eret;
        logic              in_delay_slot;
        cpu_data_t         bad_virtual_address;
    } io_to_wb_bus_t;

    typedef struct packed {
        logic              valid;
        logic              data_valid;
        register_address_t write_register;
        cpu_data_t         write_data;
    } io_to_id_back_pass_bus_t;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAIT_DATA = 2'd1,
        READY     = 2'd2,
        DISCARD   = 2'd3
    } io_state_t;

endpackage

// File: rtl/load_data_aligner.sv
// rtl/load_data_aligner.sv - little-endian load data alignment and extension
//   rdata         : raw 32-bit word from the data SRAM
//   byte_offset   : low two address bits of the access
//   load_byte/half/left/right : access type (none set = LW)
//   load_unsigned : zero-extend instead of sign-extend for LB/LH
//   write_data    : register-aligned load result
//   write_strobe  : which bytes of the destination register are updated
module load_data_aligner
    import io_stage_params::*;
(
    input  cpu_data_t  rdata,
    input  logic [1:0] byte_offset,
    input  logic       load_byte,
    input  logic       load_half,
    input  logic       load_left,
    input  logic       load_right,
    input  logic       load_unsigned,
    output cpu_data_t  write_data,
    output logic [3:0] write_strobe
);

    logic [7:0]  selected_byte;
    logic [15:0] selected_half;
    logic [4:0]  left_shift;
    logic [4:0]  right_shift;

    always_comb begin
        case (byte_offset)
            2'd0:    selected_byte = rdata[7:0];
            2'd1:    selected_byte = rdata[15:8];
            2'd2:    selected_byte = rdata[23:16];
            default: selected_byte = rdata[31:24];
        endcase
        selected_half = byte_offset[1] ? rdata[31:16] : rdata[15:0];

        // 8*(3-a) equals {~a, 3'b000} for a two-bit offset.
        left_shift  = {~byte_offset, 3'b000};
        right_shift = {byte_offset, 3'b000};

        write_data   = rdata;
        write_strobe = 4'b1111;

        if (load_byte) begin
            write_data = {{24{~load_unsigned & selected_byte[7]}}, selected_byte};
        end else if (load_half) begin
            write_data = {{16{~load_unsigned & selected_half[15]}}, selected_half};
        end else if (load_left) begin
            write_data   = rdata << left_shift;
            write_strobe = 4'b1111 << ~byte_offset;
        end else if (load_right) begin
            write_data   = rdata >> right_shift;
            write_strobe = 4'b1111 >> byte_offset;
        end
    end

endmodule

// File: rtl/io_stage.sv
// rtl/io_stage.sv - memory-response stage: collects data_ok, aligns loads, feeds WB
//   clock, reset_n           : core clock, asynchronous active-low reset
//   ex_to_io_valid/bus       : entry offered by EX
//   io_allow_in              : IO accepts an entry this cycle
//   data_ram_data_ok/rdata   : data-SRAM response for the request EX issued
//   exception_flush          : WB exception/ERET flush
//   wb_allow_in              : WB accepts
//   io_to_wb_valid/bus       : entry offered to WB
//   io_to_id_back_pass_bus   : forwarding info for ID hazard/bypass logic
module io_stage
    import io_stage_params::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ex_to_io_valid,
    input  ex_to_io_bus_t           ex_to_io_bus,
    output logic                    io_allow_in,
    input  logic                    data_ram_data_ok,
    input  cpu_data_t               data_ram_rdata,
    input  logic                    exception_flush,
    input  logic                    wb_allow_in,
    output logic                    io_to_wb_valid,
    output io_to_wb_bus_t           io_to_wb_bus,
    output io_to_id_back_pass_bus_t io_to_id_back_pass_bus
);

    io_state_t     state;
    io_state_t     state_next;
    ex_to_io_bus_t entry_q;
    cpu_data_t     load_data_q;
    logic [3:0]    load_strobe_q;

    logic          accept;
    logic          incoming_has_mem;
    logic          latch_entry;
    logic          capture_load;
    logic          entry_is_load;
    cpu_data_t     aligned_data;
    logic [3:0]    aligned_strobe;
    cpu_data_t     final_data;
    logic [3:0]    final_strobe;
    logic          unused_entry_bits;

    assign io_allow_in      = (state == EMPTY) | ((state == READY) & wb_allow_in);
    assign accept           = ex_to_io_valid & io_allow_in;
    assign incoming_has_mem = (ex_to_io_bus.result_is_from_memory | ex_to_io_bus.memory_write)
                              & ~ex_to_io_bus.exception_valid;
    // A non-memory entry handed over during a flush is simply dropped; a memory
    // one must still be tracked so its response can be swallowed.
    assign latch_entry      = accept & (~exception_flush | incoming_has_mem);
    assign capture_load     = (state == WAIT_DATA) & data_ram_data_ok;
    assign entry_is_load    = entry_q.result_is_from_memory & ~entry_q.exception_valid;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state; data_ok outside WAIT_DATA/DISCARD is a protocol error and ignored.
    always_comb begin
        state_next = state;
        if (accept) begin
            if (exception_flush) begin
                state_next = incoming_has_mem ? DISCARD : EMPTY;
            end else begin
                state_next = incoming_has_mem ? WAIT_DATA : READY;
            end
        end else begin
            case (state)
                EMPTY: begin
                    state_next = EMPTY;
                end
                READY: begin
                    if (exception_flush | wb_allow_in) begin
                        state_next = EMPTY;
                    end
                end
                WAIT_DATA: begin
                    if (exception_flush) begin
                        state_next = data_ram_data_ok ? EMPTY : DISCARD;
                    end else if (data_ram_data_ok) begin
                        state_next = READY;
                    end
                end
                DISCARD: begin
                    if (data_ram_data_ok) begin
                        state_next = EMPTY;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Entry register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_q <= '0;
        end else if (latch_entry) begin
            entry_q <= ex_to_io_bus;
        end
    end

    load_data_aligner u_load_data_aligner (
        .rdata         (data_ram_rdata),
        .byte_offset   (entry_q.memory_address[1:0]),
        .load_byte     (entry_q.memory_io_byte),
        .load_half     (entry_q.memory_io_half),
        .load_left     (entry_q.memory_io_left),
        .load_right    (entry_q.memory_io_right),
        .load_unsigned (entry_q.memory_io_unsigned),
        .write_data    (aligned_data),
        .write_strobe  (aligned_strobe)
    );

    // Load buffer: registering here keeps rdata off any combinational output path.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_data_q   <= '0;
            load_strobe_q <= '0;
        end else if (capture_load) begin
            load_data_q   <= aligned_data;
            load_strobe_q <= aligned_strobe;
        end
    end

    always_comb begin
        final_data   = entry_is_load ? load_data_q : entry_q.alu_result;
        final_strobe = 4'b0000;
        if (entry_q.register_write) begin
            final_strobe = entry_is_load ? load_strobe_q : 4'b1111;
        end
    end

    assign io_to_wb_valid = (state == READY) & ~exception_flush;

    always_comb begin
        io_to_wb_bus                     = '0;
        io_to_wb_bus.pc                  = entry_q.pc;
        io_to_wb_bus.write_register      = entry_q.write_register;
        io_to_wb_bus.write_strobe        = final_strobe;
        io_to_wb_bus.write_data          = final_data;
        io_to_wb_bus.hi_write            = entry_q.hi_write;
        io_to_wb_bus.lo_write            = entry_q.lo_write;
        io_to_wb_bus.hi_data             = entry_q.hi_data;
        io_to_wb_bus.lo_data             = entry_q.lo_data;
        io_to_wb_bus.cp0_write           = entry_q.cp0_write;
        io_to_wb_bus.cp0_address         = entry_q.cp0_address;
        io_to_wb_bus.tlb_probe           = entry_q.tlb_probe;
        io_to_wb_bus.tlb_read            = entry_q.tlb_read;
        io_to_wb_bus.tlb_write_index     = entry_q.tlb_write_index;
        io_to_wb_bus.exception_valid     = entry_q.exception_valid;
        io_to_wb_bus.exception_code      = entry_q.exception_code;
        io_to_wb_bus.eret                = entry_q.eret;
        io_to_wb_bus.in_delay_slot       = entry_q.in_delay_slot;
        io_to_wb_bus.bad_virtual_address = entry_q.bad_virtual_address;
    end

    always_comb begin
        io_to_id_back_pass_bus                = '0;
        io_to_id_back_pass_bus.valid          = (state == WAIT_DATA) | (state == READY);
        io_to_id_back_pass_bus.data_valid     = (state == READY);
        io_to_id_back_pass_bus.write_register = entry_q.register_write ? entry_q.write_register : '0;
        io_to_id_back_pass_bus.write_data     = final_data;
    end

    // Only the byte offset of the address matters past EX; the store flag is
    // already folded into the state.
    assign unused_entry_bits = ^{entry_q.memory_address[31:2], entry_q.memory_write};

endmodule

// File: tb/tb_io_stage.sv
// tb/tb_io_stage.sv - scoreboard bench for io_stage
module tb_io_stage;
    import io_stage_params::*;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic                    ex_to_io_valid;
    ex_to_io_bus_t           ex_to_io_bus;
    logic                    io_allow_in;
    logic                    data_ram_data_ok;
    cpu_data_t               data_ram_rdata;
    logic                    exception_flush;
    logic                    wb_allow_in;
    logic                    io_to_wb_valid;
    io_to_wb_bus_t           io_to_wb_bus;
    io_to_id_back_pass_bus_t io_to_id_back_pass_bus;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [3:0]  strobe;
    } expect_t;

    expect_t exp_q[$];
    int      errors = 0;
    int      checks = 0;
    bit      monitor_quiet = 1'b0;

    io_stage dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .ex_to_io_valid         (ex_to_io_valid),
        .ex_to_io_bus           (ex_to_io_bus),
        .io_allow_in            (io_allow_in),
        .data_ram_data_ok       (data_ram_data_ok),
        .data_ram_rdata         (data_ram_rdata),
        .exception_flush        (exception_flush),
        .wb_allow_in            (wb_allow_in),
        .io_to_wb_valid         (io_to_wb_valid),
        .io_to_wb_bus           (io_to_wb_bus),
        .io_to_id_back_pass_bus (io_to_id_back_pass_bus)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every cycle WB is offered an entry it must match the oldest expectation;
    // during a stall this also proves the outputs are held.
    always @(negedge clock) begin
        if (reset_n && io_to_wb_valid && !monitor_quiet) begin
            if (exp_q.size() == 0) begin
                check_value("wb_queue_size", exp_q.size(), 1);
            end else begin
                check_value("wb_pc", io_to_wb_bus.pc, exp_q[0].pc);
                check_value("wb_data", io_to_wb_bus.write_data, exp_q[0].data);
                check_value("wb_strobe", {28'd0, io_to_wb_bus.write_strobe}, {28'd0, exp_q[0].strobe});
                if (wb_allow_in) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    function automatic ex_to_io_bus_t make_alu(input logic [31:0] pc, input logic [31:0] alu);
        ex_to_io_bus_t b;
        b                = '0;
        b.pc             = pc;
        b.alu_result     = alu;
        b.memory_address = alu;
        b.register_write = 1'b1;
        b.write_register = 5'd8;
        return b;
    endfunction

    // kind: 0 LW, 1 LB, 2 LH, 3 LWL, 4 LWR
    function automatic ex_to_io_bus_t make_load(input logic [31:0] pc, input logic [1:0] a,
                                                input int kind, input bit uns);
        ex_to_io_bus_t b;
        b = make_alu(pc, 32'h1000_0000 | {30'd0, a});
        b.result_is_from_memory = 1'b1;
        b.memory_io_byte        = (kind == 1);
        b.memory_io_half        = (kind == 2);
        b.memory_io_left        = (kind == 3);
        b.memory_io_right       = (kind == 4);
        b.memory_io_unsigned    = uns;
        return b;
    endfunction

    // Hands an entry to IO; returns at 1 time unit after the accepting edge.
    task automatic offer(input ex_to_io_bus_t b);
        bit accepted;
        accepted       = 1'b0;
        ex_to_io_valid = 1'b1;
        ex_to_io_bus   = b;
        for (int n = 0; n < 100 && !accepted; n++) begin
            @(negedge clock);
            if (io_allow_in) accepted = 1'b1;
        end
        if (!accepted) begin
            check_value("accept_timeout", {31'd0, io_allow_in}, 1);
            ex_to_io_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            ex_to_io_valid = 1'b0;
        end
    endtask

    task automatic push_op(input ex_to_io_bus_t b, input bit is_mem, input int dly,
                           input logic [31:0] rd, input logic [31:0] exp_data, input logic [3:0] exp_strobe);
        expect_t e;
        offer(b);
        e.pc = b.pc; e.data = exp_data; e.strobe = exp_strobe;
        exp_q.push_back(e);
        if (!is_mem) begin
            check_value("alu_latency", {31'd0, io_to_wb_valid}, 1);
        end else begin
            repeat (dly - 1) begin
                @(posedge clock);
                #1;
            end
            check_value("mem_wait_valid", {31'd0, io_to_wb_valid}, 0);
            check_value("mem_wait_bp_valid", {31'd0, io_to_id_back_pass_bus.valid}, 1);
            data_ram_data_ok = 1'b1;
            data_ram_rdata   = rd;
            @(posedge clock);
            #1;
            data_ram_data_ok = 1'b0;
            data_ram_rdata   = $urandom;
            check_value("mem_resp_valid", {31'd0, io_to_wb_valid}, 1);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) @(posedge clock);
        #1;
        check_value("drain_left", exp_q.size(), 0);
    endtask

    task automatic pulse_data_ok(input logic [31:0] rd);
        data_ram_data_ok = 1'b1;
        data_ram_rdata   = rd;
        @(posedge clock);
        #1;
        data_ram_data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n          = 1'b1;
        ex_to_io_valid   = 1'b0;
        ex_to_io_bus     = '0;
        data_ram_data_ok = 1'b0;
        data_ram_rdata   = '0;
        exception_flush  = 1'b0;
        wb_allow_in      = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_value("rst_allow_in", {31'd0, io_allow_in}, 1);
        check_value("rst_wb_valid", {31'd0, io_to_wb_valid}, 0);
        check_value("rst_wb_pc", io_to_wb_bus.pc, 0);
        check_value("rst_wb_data", io_to_wb_bus.write_data, 0);
        check_value("rst_wb_strobe", {28'd0, io_to_wb_bus.write_strobe}, 0);
        check_value("rst_bp_valid", {31'd0, io_to_id_back_pass_bus.valid}, 0);
        check_value("rst_bp_data", io_to_id_back_pass_bus.write_data, 0);
        reset_n = 1'b1;

        // ALU op
        push_op(make_alu(32'h0000_0100, 32'h1234_5678), 0, 0, 0, 32'h1234_5678, 4'b1111);
        check_value("bp_data_valid", {31'd0, io_to_id_back_pass_bus.data_valid}, 1);
        check_value("bp_data", io_to_id_back_pass_bus.write_data, 32'h1234_5678);
        check_value("bp_wreg", {27'd0, io_to_id_back_pass_bus.write_register}, 8);

        // Loads
        push_op(make_load(32'h104, 2'd3, 1, 0), 1, 2, 32'h80AA_BBCC, 32'hFFFF_FF80, 4'b1111);
        push_op(make_load(32'h108, 2'd3, 1, 1), 1, 2, 32'h80AA_BBCC, 32'h0000_0080, 4'b1111);
        push_op(make_load(32'h10C, 2'd1, 3, 0), 1, 1, 32'h4433_2211, 32'h2211_0000, 4'b1100);
        push_op(make_load(32'h110, 2'd1, 4, 0), 1, 1, 32'h4433_2211, 32'h0044_3322, 4'b0111);
        push_op(make_load(32'h114, 2'd0, 3, 0), 1, 1, 32'h4433_2211, 32'h1100_0000, 4'b1000);
        push_op(make_load(32'h118, 2'd3, 4, 0), 1, 1, 32'h4433_2211, 32'h0000_0044, 4'b0001);
        push_op(make_load(32'h11C, 2'd2, 2, 0), 1, 1, 32'h8001_1234, 32'hFFFF_8001, 4'b1111);
        push_op(make_load(32'h120, 2'd0, 2, 1), 1, 1, 32'h8001_9234, 32'h0000_9234, 4'b1111);
        push_op(make_load(32'h124, 2'd0, 0, 0), 1, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111);

        // Store: completes on data_ok, no register write
        begin
            ex_to_io_bus_t s;
            s = make_alu(32'h128, 32'h0000_ABCD);
            s.memory_write   = 1'b1;
            s.register_write = 1'b0;
            push_op(s, 1, 2, 32'h0, 32'h0000_ABCD, 4'b0000);
            check_value("store_bp_wreg", {27'd0, io_to_id_back_pass_bus.write_register}, 0);
        end

        // Faulting load bypasses the memory wait
        begin
            ex_to_io_bus_t x;
            x = make_load(32'h12C, 2'd0, 0, 0);
            x.exception_valid = 1'b1;
            x.alu_result      = 32'h0BAD_0000;
            push_op(x, 0, 0, 0, 32'h0BAD_0000, 4'b1111);
        end
        drain();

        // Stray data_ok in EMPTY is ignored
        pulse_data_ok(32'hFFFF_FFFF);
        check_value("stray_ok_allow", {31'd0, io_allow_in}, 1);
        check_value("stray_ok_valid", {31'd0, io_to_wb_valid}, 0);

        // Flush in WAIT_DATA -> DISCARD until the owed response arrives
        offer(make_load(32'h200, 2'd0, 0, 0));
        check_value("wait_allow", {31'd0, io_allow_in}, 0);
        exception_flush = 1'b1;
        @(posedge clock);
        #1;
        exception_flush = 1'b0;
        check_value("discard_allow", {31'd0, io_allow_in}, 0);
        check_value("discard_bp_valid", {31'd0, io_to_id_back_pass_bus.valid}, 0);
        repeat (2) @(posedge clock);
        #1;
        check_value("discard_hold", {31'd0, io_allow_in}, 0);
        pulse_data_ok(32'h1111_1111);
        check_value("discard_done_allow", {31'd0, io_allow_in}, 1);
        check_value("discard_done_valid", {31'd0, io_to_wb_valid}, 0);

        // Flush and data_ok in the same WAIT_DATA cycle -> EMPTY
        offer(make_load(32'h204, 2'd0, 0, 0));
        exception_flush = 1'b1;
        pulse_data_ok(32'h2222_2222);
        exception_flush = 1'b0;
        check_value("flush_ok_allow", {31'd0, io_allow_in}, 1);
        check_value("flush_ok_valid", {31'd0, io_to_wb_valid}, 0);

        // Memory entry handed over during a flush -> DISCARD
        exception_flush = 1'b1;
        offer(make_load(32'h208, 2'd0, 0, 0));
        exception_flush = 1'b0;
        check_value("flush_in_allow", {31'd0, io_allow_in}, 0);
        pulse_data_ok(32'h3333_3333);
        check_value("flush_in_done", {31'd0, io_allow_in}, 1);

        // Non-memory entry handed over during a flush is not latched
        exception_flush = 1'b1;
        offer(make_alu(32'h20C, 32'h5555_5555));
        exception_flush = 1'b0;
        check_value("flush_alu_valid", {31'd0, io_to_wb_valid}, 0);

        // Flush while READY and stalled drops the entry
        monitor_quiet = 1'b1;
        wb_allow_in   = 1'b0;
        offer(make_alu(32'h210, 32'h6666_6666));
        exception_flush = 1'b1;
        #1;
        check_value("flush_ready_gate", {31'd0, io_to_wb_valid}, 0);
        @(posedge clock);
        #1;
        exception_flush = 1'b0;
        check_value("flush_ready_valid", {31'd0, io_to_wb_valid}, 0);
        check_value("flush_ready_allow", {31'd0, io_allow_in}, 1);
        wb_allow_in   = 1'b1;
        monitor_quiet = 1'b0;

        // Streaming ALU ops against a toggling WB
        fork
            begin
                for (int c = 0; c < 24; c++) begin
                    @(posedge clock);
                    #1;
                    wb_allow_in = ~wb_allow_in;
                end
                wb_allow_in = 1'b1;
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    push_op(make_alu(32'h300 + 32'(4 * k), 32'hA000_0000 + 32'(k)), 0, 0, 0,
                            32'hA000_0000 + 32'(k), 4'b1111);
                end
            end
        join
        drain();

        // Asynchronous reset during WAIT_DATA
        offer(make_load(32'h400, 2'd0, 0, 0));
        check_value("pre_rst_bp_valid", {31'd0, io_to_id_back_pass_bus.valid}, 1);
        #2 reset_n = 1'b0;
        #1;
        check_value("async_rst_bp_valid", {31'd0, io_to_id_back_pass_bus.valid}, 0);
        check_value("async_rst_wb_pc", io_to_wb_bus.pc, 0);
        check_value("async_rst_allow", {31'd0, io_allow_in}, 1);
        @(posedge clock);
        #1 reset_n = 1'b1;
        push_op(make_alu(32'h404, 32'h0F0F_0F0F), 0, 0, 0, 32'h0F0F_0F0F, 4'b1111);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
